// File: rtl/audio_dac_tx.sv
// I2S-style mono-to-stereo serial DAC transmitter: offset-binary samples in, bclk/lrclk/sdata out.
// Define DAC_TX_UNDERRUN_CNT_EN to add a saturating underrun_count output.
module audio_dac_tx #(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun
`ifdef DAC_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam int DW         = $clog2(CLK_DIV);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] bit_q, bit_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          und_q, und_d;
  logic          full_q, full_d;
  logic [17:0]   hold_q, hold_d;
  logic [17:0]   last_q, last_d;
  logic [17:0]   word_q, word_d;

  logic          div_wrap;
  logic          fall_evt;
  logic          frame_start;
  logic          xfer;
  logic [CW-1:0] pos;
  logic [4:0]    idx;

  // Valid/ready: a sample moves when sample_valid && sample_ready at a rising clk edge;
  // ready is simply "holding register empty", so a waiting sample is never overwritten.
  assign xfer = sample_valid && !full_q;

  always_comb begin
    div_d       = div_q;
    bit_d       = bit_q;
    bclk_d      = bclk_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    full_d      = full_q;
    hold_d      = hold_q;
    last_d      = last_q;
    word_d      = word_q;
    pos         = '0;
    idx         = '0;

    div_wrap    = (div_q == DW'(CLK_DIV - 1));
    fall_evt    = div_wrap && bclk_q;
    frame_start = fall_evt && (bit_q == CW'(FRAME_BITS - 1));
    und_d       = frame_start && !full_q;

    div_d = div_wrap ? '0 : div_q + 1'b1;
    if (div_wrap) bclk_d = ~bclk_q;

    if (fall_evt) begin
      bit_d   = frame_start ? '0 : bit_q + 1'b1;
      lrclk_d = (bit_d >= CW'(SLOT_BITS));
      pos     = lrclk_d ? bit_d - CW'(SLOT_BITS) : bit_d;
      // Position 0 is the I2S delay bit; the word is loaded on the same edge, so it is not yet needed.
      if ((pos >= CW'(1)) && (pos <= CW'(18))) begin
        idx     = 5'(CW'(18) - pos);
        sdata_d = word_q[idx];
      end else begin
        sdata_d = 1'b0;
      end
    end

    if (frame_start) begin
      if (full_q) begin
        word_d = {~hold_q[17], hold_q[16:0]};
        last_d = hold_q;
        full_d = 1'b0;
      end else begin
        word_d = {~last_q[17], last_q[16:0]};
      end
    end

    if (xfer) begin
      hold_d = sample_in;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      bit_q   <= CW'(FRAME_BITS - 1);
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      und_q   <= 1'b0;
      full_q  <= 1'b0;
      hold_q  <= '0;
      last_q  <= 18'h20000;
      word_q  <= '0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      und_q   <= und_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      word_q  <= word_d;
    end
  end

  assign sample_ready = ~full_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = und_q;

`ifdef DAC_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (und_q && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_count = ucnt_q;
`else
  // Underruns are reported only through the one-cycle pulse.
`endif

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench for audio_dac_tx (CLK_DIV=2, SLOT_BITS=32): table of samples with hand-computed
// slot bit patterns plus hand-written reset/handshake/underrun sequences.
`timescale 1ns/1ps
module tb_audio_dac_tx;
  localparam int CLK_DIV    = 2;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_CLKS = 4 * SLOT_BITS * CLK_DIV;
  localparam logic [63:0] LR_EXP = {32'hFFFF_FFFF, 32'h0000_0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, bclk, lrclk, sdata, underrun;
`ifdef DAC_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  audio_dac_tx #(.CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
`ifdef DAC_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- serial capture (sampled on negedge) ----------------
  int          pos = 63;
  bit          seen_fall = 0;
  logic        prev_bclk = 1'b0;
  logic        prev_lr = 1'b0;
  logic [63:0] cur_bits = '0;
  logic [63:0] cur_lr = '0;
  logic [63:0] cap_bits_q[$];
  logic [63:0] cap_lr_q[$];
  int          lr_rise_q[$];
  int          ur_total = 0;

  always @(negedge clk) begin
    if (rst) begin
      pos = 63; seen_fall = 0; prev_bclk = 1'b0; prev_lr = 1'b0;
      cap_bits_q.delete(); cap_lr_q.delete(); lr_rise_q.delete();
      ur_total = 0;
    end else begin
      if (underrun) ur_total++;
      if (prev_bclk && !bclk) begin
        pos = (pos == 63) ? 0 : pos + 1;
        seen_fall = 1;
      end
      if (!prev_bclk && bclk && seen_fall) begin
        cur_bits[pos] = sdata;
        cur_lr[pos]   = lrclk;
        if (pos == 63) begin
          cap_bits_q.push_back(cur_bits);
          cap_lr_q.push_back(cur_lr);
        end
      end
      if (!prev_lr && lrclk) lr_rise_q.push_back(cyc);
      prev_bclk = bclk;
      prev_lr   = lrclk;
    end
  end

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total    = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic check_frame(input string name, input logic [63:0] exp_bits);
    logic [63:0] b, l;
    if (cap_bits_q.size() == 0) begin
      total++;
      $display("FAIL %s: no frame captured, required=%h", name, exp_bits);
    end else begin
      b = cap_bits_q.pop_front();
      l = cap_lr_q.pop_front();
      check(name, b, exp_bits);
      check({name, "_lrclk"}, l, LR_EXP);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    sample_valid = 1'b0;
    tick(2);
    if (chk) begin
      check("rst_bclk", bclk, 0);
      check("rst_lrclk", lrclk, 0);
      check("rst_sdata", sdata, 0);
      check("rst_ready", sample_ready, 1);
      check("rst_underrun", underrun, 0);
    end
    rst = 1'b0;
  endtask

  // Leaves sample_valid high so back-to-back calls keep the request asserted.
  task automatic send(input logic [17:0] s);
    bit done = 0;
    int k = 0;
    sample_in    = s;
    sample_valid = 1'b1;
    while (!done && k < 4 * FRAME_CLKS) begin
      done = sample_ready;
      tick(1);
      k++;
    end
    if (!done) begin
      total++;
      $display("FAIL send_timeout: sample=%h never accepted, required ready within %0d cycles", s, 4 * FRAME_CLKS);
    end
  endtask

  task automatic wait_cap(input int n, input string name);
    int k = 0;
    while (cap_bits_q.size() < n && k < 4 * FRAME_CLKS) begin
      tick(1);
      k++;
    end
    if (cap_bits_q.size() < n) begin
      total++;
      $display("FAIL %s_timeout: frames=%0d required=%0d", name, cap_bits_q.size(), n);
    end
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [17:0] sample;
    logic [31:0] slot;   // bit p = sdata at slot position p
  } vec_t;
  vec_t vecs[6];

  initial begin
    int ur_snap;
    logic [63:0] e;

    vecs[0] = '{18'h3FFFF, 32'h0007_FFFC};
    vecs[1] = '{18'h00000, 32'h0000_0002};
    vecs[2] = '{18'h20000, 32'h0000_0000};
    vecs[3] = '{18'h1FFFF, 32'h0007_FFFE};
    vecs[4] = '{18'h2AAAA, 32'h0002_AAA8};
    vecs[5] = '{18'h20001, 32'h0004_0000};

    // Reset values and first bclk edges, then idle silence.
    do_reset(1);
    tick(1); check("bclk_c1", bclk, 0);
    tick(1); check("bclk_rise_c2", bclk, 1);
    tick(1); check("bclk_c3", bclk, 1);
    tick(1); check("bclk_fall_c4", bclk, 0);
    wait_cap(3, "idle");
    ur_snap = ur_total;
    check("idle_underruns_3_frames", ur_snap, 3);
    check_frame("idle_f0", 64'h0);
    check_frame("idle_f1", 64'h0);
    check_frame("idle_f2", 64'h0);
    if (lr_rise_q.size() >= 3) begin
      check("lrclk_period_a", lr_rise_q[1] - lr_rise_q[0], FRAME_CLKS);
      check("lrclk_period_b", lr_rise_q[2] - lr_rise_q[1], FRAME_CLKS);
    end else begin
      total++;
      $display("FAIL lrclk_period: rises=%0d required>=3", lr_rise_q.size());
    end

    // Sample written before the first frame start; ready timing around that frame start.
    do_reset(0);
    send(18'h3FFFF);
    sample_valid = 1'b0;
    check("ready_after_load", sample_ready, 0);
    tick(2); check("ready_before_fs", sample_ready, 0);
    tick(1); check("ready_after_fs", sample_ready, 1);
    wait_cap(1, "max_f0");
    check("max_f0_underruns", ur_total, 0);
    check_frame("max_f0", {32'h0007_FFFC, 32'h0007_FFFC});
    wait_cap(1, "max_f1");
    check("repeat_underrun", ur_total, 1);
    check_frame("repeat_last_f1", {32'h0007_FFFC, 32'h0007_FFFC});

    // Continuous stream: one transfer per frame, in order, no underrun.
    do_reset(0);
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].slot, vecs[i].slot});
      send(vecs[i].sample);
    end
    sample_valid = 1'b0;
    wait_cap(6, "stream");
    ur_snap = ur_total;
    check("stream_underruns", ur_snap, 0);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      check_frame($sformatf("stream_f%0d", i), e);
    end

    // One-cycle reset mid-slot with a held sample: sample dropped, silence follows.
    cap_bits_q.delete(); cap_lr_q.delete();
    wait_cap(1, "pre_rst");
    tick(20);
    send(18'h00000);
    sample_valid = 1'b0;
    tick(10);
    check("held_before_rst", sample_ready, 0);
    rst = 1'b1;
    tick(1);
    check("midrst_bclk", bclk, 0);
    check("midrst_lrclk", lrclk, 0);
    check("midrst_sdata", sdata, 0);
    check("midrst_ready", sample_ready, 1);
    check("midrst_underrun", underrun, 0);
    rst = 1'b0;
    wait_cap(1, "post_rst");
    check("post_rst_underrun", ur_total, 1);
    check_frame("post_rst_silence", 64'h0);

`ifdef DAC_TX_UNDERRUN_CNT_EN
    do_reset(0);
    check("ucnt_reset", underrun_count, 0);
    wait_cap(3, "ucnt");
    check("ucnt_3", underrun_count, 3);
    dut.ucnt_q = 16'hFFFE;
    cap_bits_q.delete(); cap_lr_q.delete();
    wait_cap(3, "ucnt_sat");
    check("ucnt_saturate", underrun_count, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/audio_dac_tx.md
Name: audio_dac_tx

Overview:
Serial audio transmitter at the output end of the voice-mixing chain. It accepts 18-bit offset-binary mixed samples (midscale 18'h20000 = silence) through a valid/ready handshake and converts them to two's complement. It serialises each sample as an I2S-style stereo frame, with the same mono sample sent on both channels, for an external audio DAC. It generates its own bit clock and word-select signals from the system clock.

Parameters:
CLK_DIV, 4, clk cycles per bclk half-period; must be >= 2; bclk period = 2*CLK_DIV clk cycles.
SLOT_BITS, 32, bclk periods per channel slot; must be >= 19; frame = 2*SLOT_BITS bclk periods.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
sample_in  in  18  offset-binary mixed sample.
sample_valid  in  1  sample_in is valid this cycle.
sample_ready  out  1  holding register is empty; a transfer occurs when sample_valid && sample_ready.
bclk  out  1  serial bit clock.
lrclk  out  1  word select; 0 = left slot, 1 = right slot.
sdata  out  1  serial data, MSB first.
underrun  out  1  one-clk pulse when a frame starts with no new sample.

Behaviour:
- Reset values: bclk=0, lrclk=0, sdata=0, sample_ready=1, underrun=0. The divider counter resets to 0 and the bit counter resets to 2*SLOT_BITS-1. The holding register is empty. The last-sample register resets to 18'h20000. Reset mid-frame aborts the frame immediately and drops any held sample.
- Divider: the counter runs 0..CLK_DIV-1. On reaching CLK_DIV-1 it wraps and bclk toggles in the same cycle. The first bclk rise is CLK_DIV cycles after reset deasserts. The first fall is 2*CLK_DIV cycles after reset deasserts.
- Bit counter: advances on each bclk falling-edge event and runs 0..2*SLOT_BITS-1, wrapping to 0. A wrap to 0 is a frame start. The first falling edge after reset is therefore a frame start.
- lrclk: 0 while bit_cnt < SLOT_BITS, else 1. It updates on the falling edge.
- Holding register: a handshake transfer loads sample_in and sets full; sample_ready = !full, registered.
- Frame start, holding register full:
  - shift word <= {~held[17], held[16:0]} (offset-binary to two's complement);
  - last-sample register <= held;
  - full cleared, so sample_ready rises the next cycle.
- Frame start, holding register empty: the shift word is rebuilt from the last-sample register and underrun pulses high for exactly one clk.
- Frame start coinciding with a handshake:
  - holding register empty: the incoming sample is captured into the holding register and is not used for this frame; underrun still pulses.
  - holding register full: no transfer is possible, because ready is low.
- Serial slot format, per channel, driven on falling edges, with slot position p = bit_cnt mod SLOT_BITS:
  - p=0 is the I2S delay bit and drives the LSB of the previous slot's data, which is 0 because of the padding;
  - p=1..18 drive word bits 17..0;
  - p=19..SLOT_BITS-1 drive 0.
  - The left and right slots carry identical data.
- sdata and lrclk are stable across each bclk rising edge.
- Throughput: one sample per frame = 4*SLOT_BITS*CLK_DIV clk cycles. Default: 512 clk cycles per sample.
- A sample presented while the holding register is full waits; it is never overwritten or lost.

Optional Feature:
Macro DAC_TX_UNDERRUN_CNT_EN.
- Defined: adds output port underrun_count [15:0].
  - Resets to 0.
  - Increments on every underrun pulse.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent, and underrun behaviour is otherwise unchanged.

Test Plan:
1. Reset, then idle with CLK_DIV=2, SLOT_BITS=32:
   - bclk rises at cycle 2 and falls at cycle 4 after reset deasserts;
   - lrclk period is 256 clk;
   - sdata is all 0 (silence from the reset value 18'h20000);
   - underrun pulses once per frame.
2. Write 18'h3FFFF before the first frame start -> each slot carries delay 0, then 0 followed by seventeen 1s, then 13 zeros. sample_ready is low until the frame start, then high the next cycle.
3. Write 18'h00000, then 18'h20000 in the following frame -> frame 1 slots are 1 followed by seventeen 0s; frame 2 slots are all zeros; no underrun in either frame.
4. Hold sample_valid high with new values continuously -> exactly one transfer per frame; no value is skipped or duplicated; sample_ready is low between frame starts.
5. Assert rst for 1 cycle mid-slot with a held sample -> outputs return to reset values on the next cycle; the held sample is discarded; the next frame sends silence and underrun pulses.
6. With DAC_TX_UNDERRUN_CNT_EN defined, run 3 frames with no input -> underrun_count = 3. Preloading the counter to 16'hFFFE and running 3 more underruns -> underrun_count holds at 16'hFFFF.
